// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch requester, data requester and memory array signals of the
// unified memory port arbiter. The arbiter connects through the slave modport;
// the requesters and the memory array connect through the master modport.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction fetch side
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   // load/store side
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   // memory array side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   // status
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port word memory between instruction fetch and load/store
// traffic. Data wins ties until it has taken MAX_DATA_STREAK grants in a row
// while a fetch was waiting; then fetch is served. Each access holds mem_en for
// MEM_LATENCY cycles, followed by one response cycle carrying the valid pulse.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MEM_LATENCY     = 2,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_port_arbiter_if.slave    bus
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STR_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STR_W-1:0] STR_MAX  = STR_W'(MAX_DATA_STREAK);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q,    state_d;
   logic              owner_q,    owner_d;    // 1 = data side owns the access
   logic              we_q,       we_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;     // already word aligned
   logic [DATA_W-1:0] wdata_q,    wdata_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [STR_W-1:0]  streak_q,   streak_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
   logic              if_gnt_c,   d_gnt_c;

   // Grant decision: only in IDLE, and never while reset is held so every output is quiet
   always_comb begin
      if_gnt_c = 1'b0;
      d_gnt_c  = 1'b0;
      if (state_q == IDLE && rst_n) begin
         if (bus.d_req && (!bus.if_req || streak_q != STR_MAX)) begin
            d_gnt_c = 1'b1;
         end else if (bus.if_req) begin
            if_gnt_c = 1'b1;
         end
      end
   end

   // Next-state logic: grant latching, latency countdown, read capture, streak tracking
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      streak_d   = streak_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (d_gnt_c) begin
               owner_d = 1'b1;
               we_d    = bus.d_we;
               addr_d  = bus.d_addr & WORD_MASK;
               wdata_d = bus.d_wdata;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
               // a data grant only counts against fairness when fetch was waiting
               if (bus.if_req) begin
                  streak_d = (streak_q == STR_MAX) ? streak_q : streak_q + 1'b1;
               end else begin
                  streak_d = '0;
               end
            end else if (if_gnt_c) begin
               owner_d  = 1'b0;
               we_d     = 1'b0;
               addr_d   = bus.if_addr & WORD_MASK;
               wdata_d  = '0;
               cnt_d    = CNT_LOAD;
               state_d  = ACCESS;
               streak_d = '0;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner_q) begin
                     d_rdata_d = bus.mem_rdata;
                  end else begin
                     if_rdata_d = bus.mem_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         streak_q   <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         streak_q   <= streak_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt_c;
   assign bus.d_gnt     = d_gnt_c;
   assign bus.mem_en    = (state_q == ACCESS);
   assign bus.mem_we    = (state_q == ACCESS) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_valid  = (state_q == RESP) && !owner_q;
   assign bus.d_valid   = (state_q == RESP) && owner_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1,
// sharing a small word memory model. Stimulus issues requests; a monitor turns
// every observed grant into an expected response and checks the access window,
// the response pulse and data, the grant order and the reset behaviour.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int ML   = 2;
   localparam int ML1  = 1;
   localparam int MAXS = 4;

   typedef struct {
      bit          own_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic mem_init;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   done = 1'b0;

   exp_t        q[$];
   exp_t        q1[$];
   bit          exp_order[$];
   logic [31:0] ref_mem [16];
   logic [31:0] mem_arr [16];
   logic [31:0] last_d;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML), .MAX_DATA_STREAK(MAXS)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML1), .MAX_DATA_STREAK(MAXS)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   function automatic logic [31:0] init_word(input int i);
      return (i == 1) ? 32'h0810_0000 : (32'hC0DE_0000 | 32'(i));
   endfunction

   // memory array model, indexed by word address bits [5:2]
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
      end else if (bus.mem_en && bus.mem_we) begin
         mem_arr[bus.mem_addr[5:2]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata  = bus.mem_en  ? mem_arr[bus.mem_addr[5:2]]  : 32'h0;
   assign bus1.mem_rdata = bus1.mem_en ? mem_arr[bus1.mem_addr[5:2]] : 32'h0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      bit   in_acc;
      bit   exp_v;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      last_d = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_ctrl", 128'({bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid,
                                  bus.mem_en, bus.mem_we, bus.busy}), 128'h0);
            chk("rst_data", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata}, 128'h0);
            chk("rst_ctrl1", 128'({bus1.if_gnt, bus1.if_valid, bus1.mem_en, bus1.busy,
                                   bus1.if_rdata}), 128'h0);
            q.delete();
            q1.delete();
            last_d = 32'h0;
         end else begin
            // ---- instance with MEM_LATENCY=2 ----
            if (q.size() > 0) begin
               e = q[0];
               in_acc = (cyc >= e.due - ML) && (cyc < e.due);
               if (cyc >= e.due - ML) begin
                  chk("acc_ctrl", 128'({bus.mem_en, bus.mem_we, bus.busy}),
                      128'({in_acc, in_acc & e.we, 1'b1}));
                  if (in_acc)
                     chk("acc_bus", 128'({bus.mem_addr, bus.mem_wdata}),
                         128'({e.addr, e.we ? e.wdata : bus.mem_wdata}));
               end
            end
            exp_v = (q.size() > 0) && (cyc == q[0].due);
            if (bus.if_valid || bus.d_valid || exp_v) begin
               if (!exp_v) begin
                  chk("unexp_valid", 128'({bus.if_valid, bus.d_valid}), 128'h0);
               end else begin
                  e = q.pop_front();
                  chk("valid", 128'({bus.if_valid, bus.d_valid}), 128'({!e.own_d, e.own_d}));
                  chk(e.own_d ? "d_rdata" : "if_rdata",
                      128'(e.own_d ? bus.d_rdata : bus.if_rdata), 128'(e.data));
               end
            end
            if (bus.if_gnt || bus.d_gnt) begin
               chk("one_gnt", 128'({bus.if_gnt, bus.d_gnt} == 2'b11), 128'h0);
               e.own_d = bus.d_gnt;
               e.we    = bus.d_gnt && bus.d_we;
               e.addr  = (bus.d_gnt ? bus.d_addr : bus.if_addr) & 32'hFFFF_FFFC;
               e.wdata = bus.d_wdata;
               e.due   = cyc + ML + 1;
               if (e.we) begin
                  e.data = last_d;
                  ref_mem[e.addr[5:2]] = e.wdata;
               end else begin
                  e.data = ref_mem[e.addr[5:2]];
                  if (e.own_d) last_d = e.data;
               end
               q.push_back(e);
               if (exp_order.size() > 0)
                  chk("gnt_order", 128'(bus.d_gnt), 128'(exp_order.pop_front()));
            end
            // ---- instance with MEM_LATENCY=1 (fetch only) ----
            if (q1.size() > 0) begin
               e = q1[0];
               if (cyc >= e.due - ML1)
                  chk("acc1_ctrl", 128'({bus1.mem_en, bus1.busy, bus1.mem_addr}),
                      128'({cyc < e.due, 1'b1, e.addr}));
            end
            exp_v = (q1.size() > 0) && (cyc == q1[0].due);
            if (bus1.if_valid || bus1.d_valid || exp_v) begin
               if (!exp_v) begin
                  chk("unexp_valid1", 128'({bus1.if_valid, bus1.d_valid}), 128'h0);
               end else begin
                  e = q1.pop_front();
                  chk("valid1", 128'({bus1.if_valid, bus1.d_valid, bus1.if_rdata}),
                      128'({2'b10, e.data}));
               end
            end
            if (bus1.if_gnt) begin
               e.own_d = 1'b0;
               e.we    = 1'b0;
               e.addr  = bus1.if_addr & 32'hFFFF_FFFC;
               e.wdata = 32'h0;
               e.data  = ref_mem[e.addr[5:2]];
               e.due   = cyc + ML1 + 1;
               q1.push_back(e);
            end
            if (done) begin
               chk("drained", 128'({q.size() == 0, q1.size() == 0, exp_order.size() == 0}),
                   128'(3'b111));
               $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
               $finish;
            end
         end
      end
   end

   // issue one request and wait (bounded) for its grant; returns in the first access cycle
   task automatic issue(input bit on1, input bit is_d, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      if (on1) begin
         bus1.if_req = 1'b1; bus1.if_addr = addr;
      end else if (is_d) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = on1 ? bus1.if_gnt : (is_d ? bus.d_gnt : bus.if_gnt);
      end
      if (!got) begin
         $display("FAIL grant_timeout: got no grant, want grant for addr %h", addr);
         $fatal(1, "no grant");
      end
      @(posedge clk); #1;
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus1.if_req = 1'b0;
   endtask

   // stimulus
   initial begin
      logic [9:0] pat;
      int         n;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = '0; bus1.d_wdata = '0;
      mem_init = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 mem_init = 1'b0; rst_n = 1'b1;

      issue(0, 0, 0, 32'h0040_0004, 32'h0);           // fetch -> 0x08100000
      repeat (4) @(posedge clk);
      issue(0, 1, 0, 32'h1000_0020, 32'h0);           // load -> 0xC0DE0008
      repeat (4) @(posedge clk);
      issue(0, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF);   // store, d_rdata keeps 0xC0DE0008
      repeat (4) @(posedge clk);
      issue(0, 1, 0, 32'h1000_0013, 32'h0);           // unaligned load -> 0xDEADBEEF
      repeat (4) @(posedge clk);

      // both requesters held: D,D,D,D,I,D,D,D,D,I
      pat = 10'b1111011110;
      for (int i = 9; i >= 0; i--) exp_order.push_back(pat[i]);
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0008;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1000_000C;
      n = 0;
      for (int k = 0; k < 200 && n < 10; k++) begin
         @(negedge clk);
         if (bus.if_gnt || bus.d_gnt) n++;
      end
      if (n < 10) begin
         $display("FAIL arb_timeout: got %0d grants, want 10", n);
         $fatal(1, "arbitration stalled");
      end
      @(posedge clk); #1;
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      repeat (4) @(posedge clk);

      issue(1, 0, 0, 32'h0040_0004, 32'h0);           // MEM_LATENCY=1 instance
      repeat (4) @(posedge clk);

      issue(0, 0, 0, 32'h0040_0010, 32'h0);           // aborted by reset in first access cycle
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      issue(0, 0, 0, 32'h0040_0004, 32'h0);           // normal after reset
      repeat (4) @(posedge clk);
      issue(0, 1, 0, 32'h1000_0010, 32'h0);           // memory retains store
      repeat (4) @(posedge clk);

      done = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_finish: got no summary, want summary");
      $fatal(1, "monitor did not finish");
   end
endmodule
